// File: rtl/mux_4_to_1_rr_arbiter_pkg.sv
// Shared encodings for the 4:1 round-robin arbiter: mux selects, FSM states,
// and the one-hot grant helper.
package mux_4_to_1_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4_to_1_rr_arbiter_rr_pick4.sv
// Combinational 4-bit rotating priority picker: returns the first set request
// at or after ptr, wrapping 3->0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] w_cand;

    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_cand = ptr + 2'(i);
            if (!found && req[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_to_1_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 mux, with a bounded burst
// length and a registered valid/ready output stage.
module mux_4_to_1_rr_arbiter
    import mux_4_to_1_rr_arbiter_pkg::*;
#(
    parameter int unsigned size      = 10,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic [size-1:0] c,
    input  logic [size-1:0] d,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [size-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_ptr;
    logic [3:0]        r_burst_cnt;
    logic [1:0]        r_sel;
    logic [size-1:0]   r_out_data;
    logic              r_out_valid;
    logic [3:0]        r_gnt;

    logic [1:0]        w_pick_idx;
    logic              w_pick_found;
    logic              w_load;
    logic              w_hold;
    logic [1:0]        w_winner;
    logic [size-1:0]   w_mux;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // found is equivalent to |req, so it doubles as the request-present term
    assign w_load   = (!r_out_valid || out_ready) && w_pick_found;
    assign w_hold   = (r_state == BURST) && req[r_sel] && (r_burst_cnt < 4'(MAX_BURST));
    assign w_winner = w_hold ? r_sel : w_pick_idx;

    always_comb begin
        w_mux = '0;
        case (w_winner)
            SEL_A:   w_mux = a;
            SEL_B:   w_mux = b;
            SEL_C:   w_mux = c;
            SEL_D:   w_mux = d;
            default: w_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = BURST;
            BURST:   if (out_ready && !w_pick_found) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_sel       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_gnt       <= '0;
        end else begin
            r_gnt <= '0;
            if (w_load) begin
                r_out_data  <= w_mux;
                r_sel       <= w_winner;
                r_out_valid <= 1'b1;
                r_gnt       <= onehot4(w_winner);
                // a capped burst re-arbitrates, so even a lone requester restarts at 1
                if (w_hold) begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                end else begin
                    r_burst_cnt <= 4'd1;
                    r_ptr       <= w_winner + 2'd1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_4_to_1_rr_arbiter.sv
// Directed bench for mux_4_to_1_rr_arbiter: one instance with MAX_BURST=4
// and one with MAX_BURST=1, checked against hand-computed values.
module tb_mux_4_to_1_rr_arbiter;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b, c, d;

    logic [3:0]   req4, gnt4;
    logic [1:0]   sel4;
    logic [W-1:0] data4;
    logic         valid4, rdy4;

    logic [3:0]   req1, gnt1;
    logic [1:0]   sel1;
    logic [W-1:0] data1;
    logic         valid1, rdy1;

    int checks   = 0;
    int failures = 0;

    logic [3:0]   fair_g [5];
    logic [1:0]   fair_s [5];
    logic [W-1:0] fair_d [5];

    always #5 clk = ~clk;

    mux_4_to_1_rr_arbiter #(.size(W), .MAX_BURST(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt4), .sel(sel4), .out_data(data4),
        .out_valid(valid4), .out_ready(rdy4)
    );

    mux_4_to_1_rr_arbiter #(.size(W), .MAX_BURST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt1), .sel(sel1), .out_data(data1),
        .out_valid(valid1), .out_ready(rdy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic [W-1:0] dat, input logic v);
        chk({tag, ".gnt"},   32'(gnt4),   32'(g));
        chk({tag, ".sel"},   32'(sel4),   32'(s));
        chk({tag, ".data"},  32'(data4),  32'(dat));
        chk({tag, ".valid"}, 32'(valid4), 32'(v));
    endtask

    task automatic chk1(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic [W-1:0] dat, input logic v);
        chk({tag, ".gnt"},   32'(gnt1),   32'(g));
        chk({tag, ".sel"},   32'(sel1),   32'(s));
        chk({tag, ".data"},  32'(data1),  32'(dat));
        chk({tag, ".valid"}, 32'(valid1), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = 10'd100; b = 10'd200; c = 10'd300; d = 10'd400;
        req4 = '0; rdy4 = 1'b1;
        req1 = '0; rdy1 = 1'b1;
        fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        fair_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fair_d = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd100};

        #1;
        chk4("reset_async", 4'b0000, 2'd0, 10'd0, 1'b0);
        chk1("reset_async1", 4'b0000, 2'd0, 10'd0, 1'b0);
        step();
        step();
        chk4("reset_held", 4'b0000, 2'd0, 10'd0, 1'b0);
        rst_n = 1'b1;

        // Burst cap with two requesters: a x4, b x4, a x4
        req4 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk4("burst_a1", 4'b0001, 2'd0, 10'd100, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk4("burst_b", 4'b0010, 2'd1, 10'd200, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk4("burst_a2", 4'b0001, 2'd0, 10'd100, 1'b1);
        end
        req4 = '0;
        step();
        chk4("burst_drain", 4'b0000, 2'd0, 10'd100, 1'b0);

        // Single requester, one-cycle latency, then drain
        req4 = 4'b0001;
        step();
        chk4("single_a", 4'b0001, 2'd0, 10'd100, 1'b1);
        req4 = '0;
        step();
        chk4("single_drop", 4'b0000, 2'd0, 10'd100, 1'b0);

        // Backpressure: ptr is 1, so c wins; five stalled cycles
        req4 = 4'b0100;
        rdy4 = 1'b0;
        step();
        chk4("bp_grant", 4'b0100, 2'd2, 10'd300, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk4("bp_stall", 4'b0000, 2'd2, 10'd300, 1'b1);
        end
        rdy4 = 1'b1;
        req4 = '0;
        chk("bp_pending", 32'(valid4 && rdy4), 32'd1);
        step();
        chk4("bp_consumed", 4'b0000, 2'd2, 10'd300, 1'b0);
        step();
        chk("bp_single_xfer", 32'(valid4), 32'd0);

        // Reset mid-burst: ptr is 3, so d streams first
        req4 = 4'b1111;
        step();
        chk4("rst_pre1", 4'b1000, 2'd3, 10'd400, 1'b1);
        step();
        chk4("rst_pre2", 4'b1000, 2'd3, 10'd400, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("rst_mid", 4'b0000, 2'd0, 10'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk4("rst_after", 4'b0001, 2'd0, 10'd100, 1'b1);
        req4 = '0;
        step();

        // Fairness with MAX_BURST=1
        req1 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("fair", fair_g[i], fair_s[i], fair_d[i], 1'b1);
        end

        // Wrap-around: d wins (ptr -> 0), then a, then d
        req1 = 4'b1000;
        step();
        chk1("wrap_d0", 4'b1000, 2'd3, 10'd400, 1'b1);
        req1 = 4'b1001;
        step();
        chk1("wrap_a", 4'b0001, 2'd0, 10'd100, 1'b1);
        step();
        chk1("wrap_d1", 4'b1000, 2'd3, 10'd400, 1'b1);
        req1 = '0;
        step();
        chk1("wrap_drain", 4'b0000, 2'd3, 10'd400, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_4_to_1_rr_arbiter.md
Name: mux_4_to_1_rr_arbiter

Overview:
- Shares one 4:1 mux datapath between four requesters (ports a..d) using round-robin arbitration with a bounded burst length.
- Registers the selected word into a valid/ready output stage and returns a one-hot grant/ack to the winning requester.
- Sits in front of the mux, drives its 2-bit select, and feeds a single downstream consumer.

Parameters:
- size, 10, data width of each requester word and of the output.
- MAX_BURST, 4, maximum consecutive transfers one requester may win while others are requesting; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit0=a, bit1=b, bit2=c, bit3=d.
- a, b, c, d  input  size each  requester data; must be stable while the matching req is high.
- gnt  output  4  one-hot, single-cycle ack; data of that requester is captured on this edge.
- sel  output  2  current mux select (index of the last winner).
- out_data  output  size  registered mux output.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Reset values (async, immediate): gnt=0, sel=0, out_data=0, out_valid=0, ptr=0, burst_cnt=0, state=IDLE.
- Load slot: load = (!out_valid || out_ready) && |req. Arbitration and capture happen only on load cycles.
- Winner (combinational):
  - If state=BURST, req[sel]=1, and burst_cnt<MAX_BURST: winner=sel.
  - Otherwise: first set req bit searching ptr, ptr+1, ..., ptr+3 mod 4 (wrap 3->0).
- On a load edge:
  - out_data <= mux(winner) with winner 0..3 -> a..d; sel <= winner; out_valid <= 1; gnt <= onehot(winner) for exactly that cycle.
  - Same winner as sel and state=BURST: burst_cnt increments.
  - New winner: burst_cnt <= 1 and ptr <= winner+1 mod 4.
- Burst cap: when burst_cnt reaches MAX_BURST, the next load re-runs the round-robin search from ptr.
  - A lone requester may then win again; burst_cnt restarts at 1.
- Not a load and out_ready=1: out_valid <= 0 and gnt=0.
- out_valid=1 and out_ready=0 (stall): out_data, sel, out_valid, ptr and burst_cnt hold; gnt=0.
- Latency: req high with an empty output stage -> gnt pulse and out_valid on the next rising edge (1 cycle).
- Throughput: one word per cycle while out_ready is held high.
- State machine:
  - IDLE: out_valid=0. Goes to BURST on load.
  - BURST: out_valid=1. Goes to IDLE on out_ready with no req; otherwise stays in BURST.
- Simultaneous out_ready and load: the old word is consumed and the new word is captured on the same edge, with no bubble.
- Requester drops req mid-burst: burst ends immediately; the next load uses round robin.
- Reset asserted mid-burst: all state clears asynchronously. The in-flight out_data is discarded and no gnt is issued.
- gnt is never asserted for a requester whose req=0. gnt always has at most one bit set.

Decomposition:
- Shared header mux_arb_defs.vh holds the select encodings (SEL_A=0..SEL_D=3) and the state encodings (IDLE=0, BURST=1).
- One natural sub-module: rr_pick4, a combinational 4-bit rotating priority picker.
  - Inputs: req[3:0], ptr[1:0]. Outputs: idx[1:0], found.
- The 4:1 data select may reuse the team's existing parameterized 4:1 mux, instantiated with size.

Test Plan:
- Single requester: a=100, req=0001, out_ready=1 -> gnt=0001 one cycle later, out_data=100, sel=0, out_valid=1; req drop -> out_valid=0 next cycle.
- Fairness: a=100, b=200, c=300, d=400, req=1111, MAX_BURST=1, out_ready=1 -> out_data sequence 100,200,300,400,100; gnt 0001,0010,0100,1000,0001.
- Burst cap: req=0011 held, MAX_BURST=4 -> 4 words of 100, then 200 x4, then 100 x4; burst_cnt never exceeds 4.
- Backpressure: req=0100, c=300, out_ready=0 for 5 cycles -> one gnt pulse only; out_data=300 and out_valid=1 held; exactly one transfer when out_ready rises.
- Wrap-around: ptr=3 after a d win, req=1001 -> next winner is a (sel=0), then d.
- Reset mid-burst: rst_n low during req=1111 streaming -> gnt, out_valid and sel zero immediately; after release the first winner is a.
